spi_xmit_engine: RTL

//  Parametrised SPI master shift engine for SPI_HOST; full-duplex successor to the 8-bit transmit shifter.

---
 rtl/spi_xmit_engine.sv | 120 ++++++++++++
 1 files changed

// File: rtl/spi_xmit_engine.sv
// spi_xmit_engine: full-duplex SPI master shift engine, one DATA_W-bit frame per start
// with selectable CPOL/CPHA, bit order and SCLK divider; all pin outputs are registered.
module spi_xmit_engine #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int EW = $clog2(2 * DATA_W);
  localparam bit POL = CPOL != 0;
  localparam bit PHA = CPHA != 0;
  localparam bit MSB = MSB_FIRST != 0;
  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;
  state_t state, state_d;
  logic [CW-1:0] div_cnt, div_d;
  logic [EW-1:0] edge_cnt, edge_d;
  logic [DATA_W-1:0] tx_sr, tx_d, rx_sr, rxs_d, rx_d, tx_shift, rx_shift;
  logic cs_d, sclk_d, mosi_d, busy_d, done_d, tick, last, tx_head, sr_head, shift_head;
  assign tick       = div_cnt == CW'(CLK_DIV - 1);
  assign last       = edge_cnt == EW'(2 * DATA_W - 1);
  assign tx_head    = MSB ? tx_data[DATA_W-1] : tx_data[0];
  assign sr_head    = MSB ? tx_sr[DATA_W-1] : tx_sr[0];
  assign tx_shift   = MSB ? {tx_sr[DATA_W-2:0], 1'b0} : {1'b0, tx_sr[DATA_W-1:1]};
  assign shift_head = MSB ? tx_shift[DATA_W-1] : tx_shift[0];
  assign rx_shift   = MSB ? {rx_sr[DATA_W-2:0], miso} : {miso, rx_sr[DATA_W-1:1]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start ? LEAD : IDLE;
      LEAD:    state_d = tick ? SHIFT : LEAD;
      SHIFT:   state_d = tick && last ? TRAIL : SHIFT;
      default: state_d = tick ? IDLE : TRAIL;
    endcase
  end
  // edge_cnt[0] == PHA marks the sampling edge; the other edge of each pair drives mosi
  always_comb begin
    cs_d   = cs_n;
    sclk_d = sclk;
    mosi_d = mosi;
    busy_d = busy;
    done_d = 1'b0;
    rx_d   = rx_data;
    tx_d   = tx_sr;
    rxs_d  = rx_sr;
    edge_d = edge_cnt;
    div_d  = '0;
    if (state == IDLE) begin
      if (start) begin
        cs_d   = 1'b0;
        busy_d = 1'b1;
        tx_d   = tx_data;
        rxs_d  = '0;
        edge_d = '0;
        mosi_d = PHA ? mosi : tx_head;
      end
    end else begin
      div_d = tick ? '0 : div_cnt + 1'b1;
      if (state == SHIFT && tick) begin
        sclk_d = ~sclk;
        edge_d = edge_cnt + 1'b1;
        if (edge_cnt[0] == PHA) rxs_d = rx_shift;
        else if (PHA) begin
          mosi_d = sr_head;
          tx_d   = tx_shift;
        end else if (!last) begin
          mosi_d = shift_head;
          tx_d   = tx_shift;
        end
      end
      if (state == TRAIL && tick) begin
        cs_d   = 1'b1;
        busy_d = 1'b0;
        mosi_d = 1'b0;
        done_d = 1'b1;
        rx_d   = rx_sr;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cs_n     <= 1'b1;
      sclk     <= POL;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      cs_n     <= cs_d;
      sclk     <= sclk_d;
      mosi     <= mosi_d;
      busy     <= busy_d;
      done     <= done_d;
      rx_data  <= rx_d;
      tx_sr    <= tx_d;
      rx_sr    <= rxs_d;
      div_cnt  <= div_d;
      edge_cnt <= edge_d;
    end
endmodule
